// File: rtl/cpu_run_controller.sv
// Run controller for the 5-stage CPU: reset sequencing, cycle accounting, halt/timeout detection.
// Optional stall/flush perf counters are built when PERF_COUNTERS_EN is defined.
module cpu_run_controller #(
    parameter int ADDR_W         = 32,
    parameter int CYC_W          = 32,
    parameter int RESET_CYCLES   = 4,
    parameter int MAX_CYCLES     = 20000,
    parameter int IDLE_PC_CYCLES = 8
) (
    input  logic              input_clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] pc,
    input  logic              hlt,
    input  logic              stall,
    input  logic              flush,
    output logic              core_rst,
    output logic              running,
    output logic              done,
    output logic              timed_out,
    output logic [CYC_W-1:0]  cycles_consumed,
    output logic [ADDR_W-1:0] halt_pc,
    output logic [CYC_W-1:0]  stall_cycles,
    output logic [CYC_W-1:0]  flush_count
);

    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [CYC_W-1:0] MAX_C = CYC_W'(MAX_CYCLES);
    localparam logic [CYC_W-1:0] IDLE_C = CYC_W'(IDLE_PC_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_HOLD,
        S_RUN,
        S_DONE,
        S_TIMEOUT
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [HOLD_W-1:0] hold_cnt;
    logic [CYC_W-1:0]  idle_cnt;
    logic [ADDR_W-1:0] last_pc;

    logic [CYC_W-1:0] cyc_inc;
    logic [CYC_W-1:0] idle_inc;
    logic             idle_halt;
    logic             halt;
    logic             tmo;
    logic             start_ok;
    logic             in_run;

    assign in_run   = (state_q == S_RUN);
    assign start_ok = start && ((state_q == S_IDLE) ||
                                (state_q == S_DONE) ||
                                (state_q == S_TIMEOUT));

    assign cyc_inc = (cycles_consumed == '1) ? cycles_consumed
                                             : cycles_consumed + 1'b1;

    assign idle_inc = (pc != last_pc) ? '0 :
                      (idle_cnt == '1) ? idle_cnt : idle_cnt + 1'b1;

    assign idle_halt = (IDLE_PC_CYCLES != 0) && (idle_inc == IDLE_C);
    assign halt      = hlt || idle_halt;
    assign tmo       = (MAX_CYCLES != 0) && !halt && (cyc_inc == MAX_C);

    always_ff @(posedge input_clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_TIMEOUT: begin
                if (start) state_d = S_RST_HOLD;
            end
            S_RST_HOLD: begin
                if (hold_cnt == HOLD_LAST) state_d = S_RUN;
            end
            S_RUN: begin
                if (halt) state_d = S_DONE;
                else if (tmo) state_d = S_TIMEOUT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge input_clk or posedge rst) begin
        if (rst) begin
            core_rst        <= 1'b1;
            running         <= 1'b0;
            done            <= 1'b0;
            timed_out       <= 1'b0;
            cycles_consumed <= '0;
            halt_pc         <= '0;
            hold_cnt        <= '0;
            idle_cnt        <= '0;
            last_pc         <= '0;
        end else begin
            core_rst <= (state_d != S_RUN);
            running  <= (state_d == S_RUN);
            if (start_ok) begin
                done            <= 1'b0;
                timed_out       <= 1'b0;
                cycles_consumed <= '0;
                halt_pc         <= '0;
                hold_cnt        <= '0;
                idle_cnt        <= '0;
                last_pc         <= '0;
            end else if (state_q == S_RST_HOLD) begin
                hold_cnt <= hold_cnt + 1'b1;
            end else if (in_run) begin
                cycles_consumed <= cyc_inc;
                idle_cnt        <= idle_inc;
                last_pc         <= pc;
                if (halt) begin
                    done    <= 1'b1;
                    halt_pc <= pc;
                end else if (tmo) begin
                    done      <= 1'b1;
                    timed_out <= 1'b1;
                    halt_pc   <= pc;
                end
            end
        end
    end

`ifdef PERF_COUNTERS_EN
    always_ff @(posedge input_clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else if (start_ok) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else if (in_run) begin
            if (stall && (stall_cycles != '1))
                stall_cycles <= stall_cycles + 1'b1;
            if (flush && (flush_count != '1))
                flush_count <= flush_count + 1'b1;
        end
    end
`else
    logic unused_perf;
    assign unused_perf  = stall ^ flush;
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller: reset hold, hlt/idle halts, timeout, restart, abort, perf.
module tb_cpu_run_controller;

    logic        input_clk;
    logic        rst;
    logic        start;
    logic [31:0] pc;
    logic        hlt;
    logic        stall;
    logic        flush;
    logic        core_rst;
    logic        running;
    logic        done;
    logic        timed_out;
    logic [31:0] cycles_consumed;
    logic [31:0] halt_pc;
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;

    int checks = 0;
    int errors = 0;

    cpu_run_controller #(
        .ADDR_W(32),
        .CYC_W(32),
        .RESET_CYCLES(4),
        .MAX_CYCLES(100),
        .IDLE_PC_CYCLES(8)
    ) dut (
        .input_clk(input_clk),
        .rst(rst),
        .start(start),
        .pc(pc),
        .hlt(hlt),
        .stall(stall),
        .flush(flush),
        .core_rst(core_rst),
        .running(running),
        .done(done),
        .timed_out(timed_out),
        .cycles_consumed(cycles_consumed),
        .halt_pc(halt_pc),
        .stall_cycles(stall_cycles),
        .flush_count(flush_count)
    );

    initial input_clk = 1'b0;
    always #5 input_clk = ~input_clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge input_clk);
        @(negedge input_clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Drives RUN cycles first..last; pc = 4 + 4*(i-1) unless stuck.
    task automatic run_cycles(input int first, input int last,
                              input int hlt_at, input int stuck_from,
                              input int stall_n, input int flush_n);
        for (int i = first; i <= last; i++) begin
            if (stuck_from != 0 && i >= stuck_from) pc = 32'h40;
            else pc = 32'(4 + 4 * (i - 1));
            hlt   = (i == hlt_at);
            stall = (i <= stall_n);
            flush = (i <= flush_n);
            tick();
        end
        hlt   = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
    endtask

    task automatic start_and_hold();
        pulse_start();
        for (int i = 0; i < 3; i++) tick();
        tick();
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        pc    = '0;
        hlt   = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        tick();
        check("rst_core_rst", core_rst, 1);
        check("rst_running", running, 0);
        check("rst_done", done, 0);
        check("rst_cycles", cycles_consumed, 0);
        rst = 1'b0;
        tick();
        check("idle_core_rst", core_rst, 1);

        pulse_start();
        check("hold1_core_rst", core_rst, 1);
        check("hold1_running", running, 0);
        for (int i = 2; i <= 4; i++) begin
            tick();
            check("holdn_core_rst", core_rst, 1);
        end
        tick();
        check("run_core_rst", core_rst, 0);
        check("run_running", running, 1);

        run_cycles(1, 37, 37, 0, 12, 3);
        check("hlt_done", done, 1);
        check("hlt_timed_out", timed_out, 0);
        check("hlt_cycles", cycles_consumed, 37);
        check("hlt_pc", halt_pc, 32'h94);
        check("hlt_core_rst", core_rst, 1);
        check("hlt_running", running, 0);
`ifdef PERF_COUNTERS_EN
        check("perf_stall", stall_cycles, 12);
        check("perf_flush", flush_count, 3);
`else
        check("perf_stall", stall_cycles, 0);
        check("perf_flush", flush_count, 0);
`endif
        pc = 32'h200;
        tick();
        tick();
        check("sticky_done", done, 1);
        check("sticky_cycles", cycles_consumed, 37);
        check("sticky_pc", halt_pc, 32'h94);

        pulse_start();
        check("restart_done", done, 0);
        check("restart_cycles", cycles_consumed, 0);
        check("restart_pc", halt_pc, 0);
        check("restart_stall", stall_cycles, 0);
        check("restart_core_rst", core_rst, 1);
        for (int i = 0; i < 4; i++) tick();
        check("restart_running", running, 1);

        run_cycles(1, 17, 0, 10, 0, 0);
        check("idle17_running", running, 1);
        check("idle17_done", done, 0);
        run_cycles(18, 18, 0, 10, 0, 0);
        check("idle_done", done, 1);
        check("idle_timed_out", timed_out, 0);
        check("idle_cycles", cycles_consumed, 18);
        check("idle_pc", halt_pc, 32'h40);

        start_and_hold();
        run_cycles(1, 99, 0, 0, 0, 0);
        check("tmo99_running", running, 1);
        run_cycles(100, 100, 0, 0, 0, 0);
        check("tmo_done", done, 1);
        check("tmo_timed_out", timed_out, 1);
        check("tmo_cycles", cycles_consumed, 100);
        check("tmo_pc", halt_pc, 32'h190);
        check("tmo_core_rst", core_rst, 1);

        start_and_hold();
        check("tmo_restart_flag", timed_out, 0);
        run_cycles(1, 100, 100, 0, 0, 0);
        check("tie_done", done, 1);
        check("tie_timed_out", timed_out, 0);
        check("tie_cycles", cycles_consumed, 100);

        start_and_hold();
        run_cycles(1, 49, 0, 0, 0, 0);
        check("abort_pre_cycles", cycles_consumed, 49);
        pc  = 32'h100;
        rst = 1'b1;
        #1;
        check("abort_core_rst", core_rst, 1);
        check("abort_running", running, 0);
        check("abort_cycles", cycles_consumed, 0);
        check("abort_pc", halt_pc, 0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("abort_idle_running", running, 0);
        check("abort_idle_core_rst", core_rst, 1);
        check("abort_idle_cycles", cycles_consumed, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
